l1_cache_arb: RTL and testbench

Two-port memory arbiter between the L1 instruction cache fill port (IC_arb_bus side) and the L1 data cache fill/writeback port (DC_arb_bus side), sharing a single system-memory port (sysmem_bus side). It transfers whole cache lines: the I$ port is read-only, and the D$ port does line reads and line writebacks. It sits between the two L1 caches and the system memory model or controller, and is synthesizable.

---
 rtl/l1_cache_arb_pkg.sv | 27 ++
 rtl/l1_cache_arb.sv | 144 ++++++++++++++
 tb/tb_l1_cache_arb.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l1_cache_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | l1_cache_arb_pkg : shared line geometry and arbiter state encoding |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package l1_cache_arb_pkg;

  localparam int unsigned c_a_sz_def   = 32;
  localparam int unsigned c_cl_len_def = 256;

  // Byte-offset bits inside one cache line.
  function automatic int unsigned line_off_bits(input int unsigned cl_len);
    return $clog2(cl_len / 8);
  endfunction

  localparam int unsigned c_off_bits_def = line_off_bits(c_cl_len_def);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BUSY_IC = 3'd1,
    ST_BUSY_DC = 3'd2,
    ST_DONE_IC = 3'd3,
    ST_DONE_DC = 3'd4
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/l1_cache_arb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | l1_cache_arb : I$/D$ line-fill arbiter onto one system-memory port |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module l1_cache_arb
  import l1_cache_arb_pkg::*;
#(
  parameter int unsigned A_SZ   = c_a_sz_def,
  parameter int unsigned CL_LEN = c_cl_len_def
) (
  input  logic              clk_in,
  input  logic              reset_in,

  input  logic              ic_req,
  input  logic [A_SZ-1:0]   ic_addr,
  output logic              ic_ack,
  output logic [CL_LEN-1:0] ic_rd_data,

  input  logic              dc_req,
  input  logic              dc_rw,
  input  logic [A_SZ-1:0]   dc_addr,
  input  logic [CL_LEN-1:0] dc_wr_data,
  output logic              dc_ack,
  output logic [CL_LEN-1:0] dc_rd_data,

  output logic              sm_req,
  output logic              sm_rw,
  output logic [A_SZ-1:0]   sm_addr,
  output logic [CL_LEN-1:0] sm_wr_data,
  input  logic              sm_ack,
  input  logic [CL_LEN-1:0] sm_rd_data
);

  localparam int unsigned     c_off_bits  = line_off_bits(CL_LEN);
  localparam logic [A_SZ-1:0] c_line_mask = ~A_SZ'((64'd1 << c_off_bits) - 64'd1);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic              r_last_grant_dc;
  logic              r_sm_req;
  logic              r_sm_rw;
  logic [A_SZ-1:0]   r_sm_addr;
  logic [CL_LEN-1:0] r_sm_wr_data;
  logic [CL_LEN-1:0] r_ic_rd_data;
  logic [CL_LEN-1:0] r_dc_rd_data;

  logic              w_grant_ic;
  logic              w_grant_dc;
  logic              w_mem_done;
  logic [A_SZ-1:0]   w_ic_line_addr;
  logic [A_SZ-1:0]   w_dc_line_addr;

  assign w_ic_line_addr = ic_addr & c_line_mask;
  assign w_dc_line_addr = dc_addr & c_line_mask;

  // sm_ack only counts while a transfer is outstanding.
  assign w_mem_done = sm_ack && ((r_state == ST_BUSY_IC) || (r_state == ST_BUSY_DC));

  always_comb begin
    w_state_nxt = r_state;
    w_grant_ic  = 1'b0;
    w_grant_dc  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ic_req && dc_req) begin
          w_grant_ic = r_last_grant_dc;
          w_grant_dc = !r_last_grant_dc;
        end else begin
          w_grant_ic = ic_req;
          w_grant_dc = dc_req;
        end
        if (w_grant_ic) begin
          w_state_nxt = ST_BUSY_IC;
        end else if (w_grant_dc) begin
          w_state_nxt = ST_BUSY_DC;
        end
      end
      ST_BUSY_IC: begin
        if (sm_ack) begin
          w_state_nxt = ST_DONE_IC;
        end
      end
      ST_BUSY_DC: begin
        if (sm_ack) begin
          w_state_nxt = ST_DONE_DC;
        end
      end
      ST_DONE_IC: w_state_nxt = ST_IDLE;
      ST_DONE_DC: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_state         <= ST_IDLE;
      r_last_grant_dc <= 1'b0;
      r_sm_req        <= 1'b0;
      r_sm_rw         <= 1'b0;
      r_sm_addr       <= '0;
      r_sm_wr_data    <= '0;
      r_ic_rd_data    <= '0;
      r_dc_rd_data    <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_grant_ic) begin
        r_last_grant_dc <= 1'b0;
        r_sm_req        <= 1'b1;
        r_sm_rw         <= 1'b0;
        r_sm_addr       <= w_ic_line_addr;
        r_sm_wr_data    <= '0;
      end else if (w_grant_dc) begin
        r_last_grant_dc <= 1'b1;
        r_sm_req        <= 1'b1;
        r_sm_rw         <= dc_rw;
        r_sm_addr       <= w_dc_line_addr;
        r_sm_wr_data    <= dc_wr_data;
      end

      if (w_mem_done) begin
        r_sm_req <= 1'b0;
        // A writeback completion leaves the D$ read line untouched.
        if (r_state == ST_BUSY_IC) begin
          r_ic_rd_data <= sm_rd_data;
        end else if (!r_sm_rw) begin
          r_dc_rd_data <= sm_rd_data;
        end
      end
    end
  end

  assign ic_ack     = (r_state == ST_DONE_IC);
  assign dc_ack     = (r_state == ST_DONE_DC);
  assign ic_rd_data = r_ic_rd_data;
  assign dc_rd_data = r_dc_rd_data;
  assign sm_req     = r_sm_req;
  assign sm_rw      = r_sm_rw;
  assign sm_addr    = r_sm_addr;
  assign sm_wr_data = r_sm_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_l1_cache_arb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_l1_cache_arb : scoreboard bench for the L1 line-fill arbiter    |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_l1_cache_arb;
  import l1_cache_arb_pkg::*;

  localparam int A_SZ   = 32;
  localparam int CL_LEN = 256;

  typedef logic [CL_LEN-1:0] line_t;
  typedef logic [A_SZ-1:0]   addr_t;
  typedef struct {
    addr_t addr;
    logic  rw;
    line_t wdata;
    line_t rdata;
    int    delay;
  } sm_txn_t;

  localparam line_t L1    = {8{32'hA1A1_0001}};
  localparam line_t L2    = {8{32'hB2B2_0002}};
  localparam line_t D_WB  = {8{32'hC3C3_0003}};
  localparam line_t JUNK  = {8{32'hDEAD_BEEF}};
  localparam line_t L3    = {8{32'h3333_0303}};
  localparam line_t L4    = {8{32'h4444_0404}};
  localparam line_t L5    = {8{32'h5555_0505}};
  localparam line_t L6    = {8{32'h6666_0606}};
  localparam line_t L7    = {8{32'h7777_0707}};
  localparam line_t L8    = {8{32'h8888_0808}};
  localparam line_t L9    = {8{32'h9999_0909}};
  localparam line_t STRAY = {8{32'h5757_7A7A}};

  logic  clk_in = 1'b0;
  logic  reset_in = 1'b0;
  logic  ic_req = 1'b0;
  addr_t ic_addr = '0;
  logic  ic_ack;
  line_t ic_rd_data;
  logic  dc_req = 1'b0;
  logic  dc_rw = 1'b0;
  addr_t dc_addr = '0;
  line_t dc_wr_data = '0;
  logic  dc_ack;
  line_t dc_rd_data;
  logic  sm_req;
  logic  sm_rw;
  addr_t sm_addr;
  line_t sm_wr_data;
  logic  sm_ack = 1'b0;
  line_t sm_rd_data = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int stray_cnt = 0;
  int abort_cnt = 0;

  sm_txn_t sm_q[$];
  line_t   ic_exp_q[$];
  line_t   dc_exp_q[$];

  l1_cache_arb #(.A_SZ(A_SZ), .CL_LEN(CL_LEN)) dut (
    .clk_in     (clk_in),
    .reset_in   (reset_in),
    .ic_req     (ic_req),
    .ic_addr    (ic_addr),
    .ic_ack     (ic_ack),
    .ic_rd_data (ic_rd_data),
    .dc_req     (dc_req),
    .dc_rw      (dc_rw),
    .dc_addr    (dc_addr),
    .dc_wr_data (dc_wr_data),
    .dc_ack     (dc_ack),
    .dc_rd_data (dc_rd_data),
    .sm_req     (sm_req),
    .sm_rw      (sm_rw),
    .sm_addr    (sm_addr),
    .sm_wr_data (sm_wr_data),
    .sm_ack     (sm_ack),
    .sm_rd_data (sm_rd_data)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input line_t act, input line_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  task automatic push_sm(input addr_t a, input logic rw, input line_t wd, input line_t rd,
                         input int dly);
    sm_txn_t t;
    t.addr = a; t.rw = rw; t.wdata = wd; t.rdata = rd; t.delay = dly;
    sm_q.push_back(t);
  endtask

  // Ack monitor: every ack pulse must match one queued expectation.
  initial begin
    forever begin
      @(negedge clk_in);
      if (ic_ack === 1'b1) begin
        if (ic_exp_q.size() == 0) fail_now("ic_ack_unexpected");
        else chk("ic_rd_data", ic_rd_data, ic_exp_q.pop_front());
      end
      if (dc_ack === 1'b1) begin
        if (dc_exp_q.size() == 0) fail_now("dc_ack_unexpected");
        else chk("dc_rd_data", dc_rd_data, dc_exp_q.pop_front());
      end
    end
  end

  // System memory model: checks each request against the expected order.
  initial begin
    sm_txn_t cur;
    sm_txn_t snap;
    bit      active = 1'b0;
    int      cnt = 0;
    int      stray_seen = 0;
    int      abort_seen = 0;
    forever begin
      @(negedge clk_in);
      sm_ack = 1'b0;
      if (abort_cnt != abort_seen) begin
        abort_seen = abort_cnt;
        active = 1'b0;
      end
      if (!active && sm_req === 1'b1) begin
        if (sm_q.size() == 0) begin
          fail_now("sm_req_unexpected");
        end else begin
          cur = sm_q.pop_front();
          chk("sm_addr", sm_addr, cur.addr);
          chk("sm_rw", sm_rw, cur.rw);
          if (cur.rw) chk("sm_wr_data", sm_wr_data, cur.wdata);
          snap.addr = sm_addr; snap.rw = sm_rw; snap.wdata = sm_wr_data;
          cnt = cur.delay;
          active = 1'b1;
        end
      end else if (active) begin
        chk("sm_req_held", sm_req, 1'b1);
        chk("sm_addr_held", sm_addr, snap.addr);
        chk("sm_rw_held", sm_rw, snap.rw);
        chk("sm_wr_data_held", sm_wr_data, snap.wdata);
      end
      if (active) begin
        if (cnt == 0) begin
          sm_ack = 1'b1;
          sm_rd_data = cur.rdata;
          active = 1'b0;
        end else begin
          cnt--;
        end
      end else if (stray_cnt != stray_seen) begin
        stray_seen = stray_cnt;
        sm_ack = 1'b1;
        sm_rd_data = STRAY;
      end
    end
  end

  task automatic ic_read(input addr_t a, input line_t exp, input bit hold);
    bit got = 1'b0;
    @(negedge clk_in);
    ic_req = 1'b1;
    ic_addr = a;
    ic_exp_q.push_back(exp);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_in);
      if (ic_ack === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_now("ic_ack_timeout");
    if (hold) @(negedge clk_in);
    ic_req = 1'b0;
  endtask

  task automatic dc_op(input addr_t a, input logic rw, input line_t wd, input line_t exp,
                       input bit hold);
    bit got = 1'b0;
    @(negedge clk_in);
    dc_req = 1'b1;
    dc_rw = rw;
    dc_addr = a;
    dc_wr_data = wd;
    dc_exp_q.push_back(exp);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_in);
      if (dc_ack === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_now("dc_ack_timeout");
    if (hold) @(negedge clk_in);
    dc_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    reset_in = 1'b0;
    repeat (2) @(negedge clk_in);
    reset_in = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk_in);
    reset_in = 1'b1;
    @(negedge clk_in);
    chk("rst_sm_req", sm_req, 1'b0);
    chk("rst_ic_ack", ic_ack, 1'b0);
    chk("rst_dc_ack", dc_ack, 1'b0);
    chk("rst_sm_addr", sm_addr, '0);
    chk("rst_ic_rd_data", ic_rd_data, '0);
    chk("rst_dc_rd_data", dc_rd_data, '0);

    // IC-only read, offset bits cleared, memory answers after 3 cycles
    push_sm(32'h0000_1220, 1'b0, '0, L1, 3);
    ic_read(32'h0000_1234, L1, 1'b0);

    // DC read with minimum round trip, then writeback with junk on sm_rd_data
    push_sm(32'h0000_2040, 1'b0, '0, L2, 0);
    dc_op(32'h0000_2047, 1'b0, '0, L2, 1'b0);
    push_sm(32'h0000_0100, 1'b1, D_WB, JUNK, 2);
    dc_op(32'h0000_0100, 1'b1, D_WB, L2, 1'b0);

    // Ties after reset: DC, IC, then DC, IC again
    do_reset();
    push_sm(32'h0000_3000, 1'b0, '0, L3, 1);
    push_sm(32'h0000_4000, 1'b0, '0, L4, 0);
    fork
      ic_read(32'h0000_4000, L4, 1'b0);
      dc_op(32'h0000_3000, 1'b0, '0, L3, 1'b0);
    join
    push_sm(32'h0000_5000, 1'b0, '0, L5, 2);
    push_sm(32'h0000_6000, 1'b0, '0, L6, 1);
    fork
      ic_read(32'h0000_601C, L6, 1'b0);
      dc_op(32'h0000_5008, 1'b0, '0, L5, 1'b0);
    join

    // Requestor keeps req high through its ack cycle
    push_sm(32'h0000_7000, 1'b0, '0, L7, 1);
    ic_read(32'h0000_7000, L7, 1'b1);
    repeat (10) @(negedge clk_in);

    // Asynchronous reset in the middle of a D$ transfer
    push_sm(32'h0000_8000, 1'b0, '0, L8, 40);
    @(negedge clk_in);
    dc_req = 1'b1;
    dc_rw = 1'b0;
    dc_addr = 32'h0000_8010;
    repeat (3) @(negedge clk_in);
    chk("busy_sm_req", sm_req, 1'b1);
    #2;
    reset_in = 1'b0;
    abort_cnt++;
    #1;
    chk("arst_sm_req", sm_req, 1'b0);
    chk("arst_sm_rw", sm_rw, 1'b0);
    chk("arst_sm_addr", sm_addr, '0);
    chk("arst_sm_wr_data", sm_wr_data, '0);
    chk("arst_ic_ack", ic_ack, 1'b0);
    chk("arst_dc_ack", dc_ack, 1'b0);
    chk("arst_ic_rd_data", ic_rd_data, '0);
    chk("arst_dc_rd_data", dc_rd_data, '0);
    dc_req = 1'b0;
    repeat (2) @(negedge clk_in);
    reset_in = 1'b1;
    repeat (3) @(negedge clk_in);
    chk("post_rst_sm_req", sm_req, 1'b0);
    push_sm(32'h0000_9000, 1'b0, '0, L9, 1);
    ic_read(32'h0000_9004, L9, 1'b0);

    // Stray sm_ack in IDLE must not produce an ack or touch rd_data
    repeat (2) @(negedge clk_in);
    stray_cnt++;
    repeat (4) begin
      @(negedge clk_in);
      chk("stray_ic_ack", ic_ack, 1'b0);
      chk("stray_dc_ack", dc_ack, 1'b0);
    end
    chk("stray_ic_rd_data", ic_rd_data, L9);
    chk("stray_dc_rd_data", dc_rd_data, '0);

    repeat (5) @(negedge clk_in);
    chk("sm_q_drained", line_t'(sm_q.size()), '0);
    chk("ic_q_drained", line_t'(ic_exp_q.size()), '0);
    chk("dc_q_drained", line_t'(dc_exp_q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
